// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding, default widths and width helper for the PUF verifier
package puf_pkg;
  typedef enum logic [2:0] {IDLE, PRESET, EVAL, CAPTURE, COMPARE, FINISH} state_t;
  localparam int CW_DEF = 8;
  localparam int RW_DEF = 8;
  function automatic int clog2(input int v);
    for (int r = 0; r < 31; r++) if ((1 << r) >= v) return r;
    return 31;
  endfunction
endpackage

// File: rtl/hamming_popcount.sv
// hamming_popcount: number of differing bits between two W-bit words
module hamming_popcount import puf_pkg::*; #(
  parameter int W  = RW_DEF,
  parameter int HW = clog2(W + 1)
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [HW-1:0] hd
);
  // accumulate one per mismatching bit position
  always_comb begin
    hd = '0;
    for (int i = 0; i < W; i++) hd = hd + HW'(a[i] ^ b[i]);
  end
endmodule

// File: rtl/puf_auth_verifier.sv
// puf_auth_verifier: issues challenges to a ring-oscillator PUF, enrolls golden CRPs and verifies responses by Hamming distance
module puf_auth_verifier import puf_pkg::*; #(
  parameter int CW          = CW_DEF,
  parameter int RW          = RW_DEF,
  parameter int NUM_CHAL    = 4,
  parameter int EVAL_CYCLES = 1024,
  parameter int HD_MAX      = 2,
  parameter int FAIL_MAX    = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               enroll,
  input  logic [CW-1:0]                      chal_base,
  output logic [0:CW-1]                      puf_challenge,
  output logic                               puf_reset,
  output logic                               puf_en,
  input  logic [0:RW-1]                      puf_response,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic                               enrolled,
  output logic [clog2(NUM_CHAL*RW+1)-1:0]    hd_total
);
  localparam int IW = clog2(NUM_CHAL + 1);
  localparam int EW = clog2(EVAL_CYCLES + 1);
  localparam int HW = clog2(RW + 1);
  localparam int TW = clog2(NUM_CHAL * RW + 1);
  state_t                 state;
  logic                   mode;
  logic [CW-1:0]          base;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          fail_cnt;
  logic [IW-1:0]          fail_nx;
  logic [EW-1:0]          ecnt;
  logic [RW-1:0]          resp_q;
  logic [NUM_CHAL*RW-1:0] store;
  logic [HW-1:0]          hd;
  logic                   last;
  logic                   skip;
  hamming_popcount #(.W(RW), .HW(HW)) u_hd (
    .a  (resp_q),
    .b  (store[int'(idx)*RW +: RW]),
    .hd (hd)
  );
  assign fail_nx = fail_cnt + IW'(int'(hd) > HD_MAX);
  assign last    = int'(idx) == NUM_CHAL - 1;
  assign skip    = !mode && !enrolled;
  // run sequencer; every PUF-facing and host-facing output is registered on the transition into its state
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mode          <= 1'b0;
      base          <= '0;
      idx           <= '0;
      fail_cnt      <= '0;
      ecnt          <= '0;
      resp_q        <= '0;
      store         <= '0;
      puf_challenge <= '0;
      puf_reset     <= 1'b0;
      puf_en        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      enrolled      <= 1'b0;
      hd_total      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= PRESET;
          mode     <= enroll;
          base     <= chal_base;
          idx      <= '0;
          fail_cnt <= '0;
          hd_total <= '0;
          busy     <= 1'b1;
          pass     <= 1'b0;
          if (enroll || enrolled) begin
            puf_challenge <= chal_base;
            puf_reset     <= 1'b1;
          end
        end
        PRESET: if (skip) begin
          state <= FINISH;
          done  <= 1'b1;
        end else begin
          state     <= EVAL;
          puf_reset <= 1'b0;
          puf_en    <= 1'b1;
          ecnt      <= '0;
        end
        EVAL: begin
          ecnt <= ecnt + 1'b1;
          if (int'(ecnt) == EVAL_CYCLES - 1) begin
            state  <= CAPTURE;
            puf_en <= 1'b0;
          end
        end
        CAPTURE: begin
          resp_q <= puf_response;
          state  <= COMPARE;
        end
        COMPARE: begin
          if (mode) store[int'(idx)*RW +: RW] <= resp_q;
          else begin
            hd_total <= hd_total + TW'(hd);
            fail_cnt <= fail_nx;
          end
          if (last) begin
            state    <= FINISH;
            done     <= 1'b1;
            enrolled <= mode || enrolled;
            pass     <= mode || (int'(fail_nx) <= FAIL_MAX);
          end else begin
            idx           <= idx + 1'b1;
            state         <= PRESET;
            puf_challenge <= base + CW'(idx) + 1'b1;
            puf_reset     <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_puf_auth_verifier.sv
// tb_puf_auth_verifier: random and directed enroll/verify runs against a behavioural PUF and CRP model
module tb_puf_auth_verifier;
  localparam int NC  = 4;
  localparam int EC  = 4;
  localparam int HDM = 2;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       enroll = 1'b0;
  logic [7:0] chal_base = '0;
  logic [0:7] puf_challenge;
  logic [0:7] puf_response;
  logic       puf_reset, puf_en, busy, done, pass, enrolled;
  logic [5:0] hd_total;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] noise [256];
  logic [7:0] gold [NC];
  bit         m_enrolled = 1'b0;
  logic [7:0] chq [$];
  bit         en_seen, unstable;
  int         pcnt = 0;
  always #5 clk = ~clk;
  puf_auth_verifier #(
    .CW(8), .RW(8), .NUM_CHAL(NC), .EVAL_CYCLES(EC), .HD_MAX(HDM), .FAIL_MAX(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .enroll(enroll), .chal_base(chal_base),
    .puf_challenge(puf_challenge), .puf_reset(puf_reset), .puf_en(puf_en),
    .puf_response(puf_response), .busy(busy), .done(done), .pass(pass),
    .enrolled(enrolled), .hd_total(hd_total)
  );
  // PUF model: response is only correct after exactly EC enabled cycles since its counter reset
  always @(posedge clk) pcnt <= puf_reset ? 0 : pcnt + int'(puf_en);
  always_comb puf_response = (puf_challenge ^ 8'hA5 ^ noise[puf_challenge]) ^ {8{pcnt != EC}};
  // record issued challenges and watch challenge stability while the oscillator runs
  always @(negedge clk) begin
    if (puf_reset) chq.push_back(puf_challenge);
    if (puf_en) begin
      en_seen = 1'b1;
      if (chq.size() == 0 || puf_challenge != chq[$]) unstable = 1'b1;
    end
  end
  function automatic logic [7:0] good(input logic [7:0] c);
    return c ^ 8'hA5 ^ noise[c];
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input bit enr, input logic [7:0] base, input bit poke);
    int n, bcnt, exp_lat, exp_hd, fails, h;
    bit active, exp_pass;
    logic [7:0] ch, r;
    active  = enr || m_enrolled;
    exp_lat = active ? 1 + NC * (EC + 3) : 2;
    exp_hd  = 0;
    fails   = 0;
    for (int i = 0; i < NC; i++) begin
      ch = 8'(base + i);
      r  = good(ch);
      if (enr) gold[i] = r;
      else if (active) begin
        h = $countones(r ^ gold[i]);
        exp_hd += h;
        fails += int'(h > HDM);
      end
    end
    exp_pass = enr || (active && fails == 0);
    if (enr) m_enrolled = 1'b1;
    @(negedge clk);
    chq.delete();
    en_seen  = 1'b0;
    unstable = 1'b0;
    start     = 1'b1;
    enroll    = enr;
    chal_base = base;
    n    = 0;
    bcnt = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start     = poke && n == 5;
      enroll    = ~enr;
      chal_base = ~base;
      if (busy) bcnt++;
      if (done) break;
    end
    chk("latency", n, exp_lat);
    chk("busy_cycles", bcnt, exp_lat);
    chk("pass", pass, exp_pass);
    chk("hd_total", hd_total, exp_hd);
    chk("enrolled", enrolled, m_enrolled);
    chk("en_seen", en_seen, active);
    chk("chal_stable", unstable, 0);
    chk("chal_count", chq.size(), active ? NC : 0);
    for (int i = 0; i < chq.size() && i < NC; i++) chk("chal_value", chq[i], 8'(base + i));
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
  endtask
  initial begin
    int dcnt;
    bit e;
    logic [7:0] b, eb;
    foreach (noise[c]) noise[c] = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_enrolled", enrolled, 0);
    chk("rst_hd", hd_total, 0);
    chk("rst_puf", {puf_en, puf_reset}, 0);
    chk("rst_chal", puf_challenge, 0);
    reset = 1'b0;
    run(1'b0, 8'h33, 1'b0);
    run(1'b1, 8'h10, 1'b0);
    chk("t1_enrolled", enrolled, 1);
    run(1'b0, 8'h10, 1'b0);
    chk("t2_hd", hd_total, 0);
    noise[8'h12] = 8'h07;
    run(1'b0, 8'h10, 1'b0);
    chk("t3_hd3", hd_total, 3);
    chk("t3_pass3", pass, 0);
    noise[8'h12] = 8'h03;
    run(1'b0, 8'h10, 1'b0);
    chk("t3_hd2", hd_total, 2);
    chk("t3_pass2", pass, 1);
    run(1'b1, 8'hFE, 1'b1);
    chk("t5_idle_chal", puf_challenge, 8'h01);
    @(negedge clk);
    start     = 1'b1;
    enroll    = 1'b1;
    chal_base = 8'h40;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("t6_in_eval", {puf_en, chq[$]}, {1'b1, 8'h41});
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_enrolled = 1'b0;
    chk("t6_puf", {puf_en, puf_reset}, 0);
    chk("t6_busy", busy, 0);
    chk("t6_enrolled", enrolled, 0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    chk("t6_no_done", dcnt, 0);
    run(1'b0, 8'h40, 1'b0);
    eb = 8'h40;
    for (int k = 0; k < 24; k++) begin
      e = $urandom_range(0, 3) == 0;
      b = (e || $urandom_range(0, 3) == 0) ? 8'($urandom) : eb;
      if (e) eb = b;
      for (int i = 0; i < NC; i++) noise[8'(b + i)] = 8'($urandom & $urandom & $urandom);
      run(e, b, 1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
